// File: rtl/ram_parity_pkg.sv
// Purpose: shared widths, response record and byte-parity helpers for the parity adapter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// RAM word layout is {parity[NB-1:0], data[DataWidth-1:0]} with even parity
// per data byte: p[i] = ^data[8i+:8].
package ram_parity_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned NB        = DataWidth / 8;
  localparam int unsigned RamWidth  = DataWidth + NB;

  // One entry of the response queue.
  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 rerr;
  } rsp_t;

  // Even parity bit for every data byte lane.
  function automatic logic [NB-1:0] byte_parity(input logic [DataWidth-1:0] data);
    logic [NB-1:0] p;
    for (int i = 0; i < int'(NB); i++) begin
      p[i] = ^data[8*i +: 8];
    end
    return p;
  endfunction

  // Expand byte enables into a RAM bit mask covering both the data byte and
  // its parity bit, so a partial write never leaves stale parity behind.
  function automatic logic [RamWidth-1:0] be_to_mask(input logic [NB-1:0] be);
    logic [RamWidth-1:0] m;
    m = '0;
    for (int i = 0; i < int'(NB); i++) begin
      m[8*i +: 8]     = {8{be[i]}};
      m[DataWidth+i]  = be[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Purpose: small synchronous FIFO holding host responses in request order.
// Latency: a push is visible at the head one cycle later; head is combinational.
// Backpressure: push is ignored when full unless a pop frees the slot that cycle.
//
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wdata_i enqueue;
//        pop_i dequeue; rdata_o head entry; full_o/empty_o/count_o status.
module ram_rsp_fifo #(
  parameter  int unsigned Width = 33,
  parameter  int unsigned Depth = 2,
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full_o    = (r_count == CntW'(Depth));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign rdata_o   = r_mem[r_rd_ptr];
  assign w_do_pop  = pop_i & ~empty_o;
  // When full, the slot being read out this cycle may be refilled.
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wdata_i;
        r_wr_ptr        <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ram_1p_parity_adapter.sv
// Purpose: host req/gnt front end for a single-port RAM, adding per-byte even parity on writes,
//          checking it on reads, returning in-order responses and logging parity errors.
// Latency: grant in cycle T -> response pushed at the T+1 edge -> host_rvalid_o from T+2.
// Backpressure: grant is withheld while queued plus in-flight responses (less a same-cycle pop)
//               would reach RspDepth; a stalled host_rready_i therefore stalls new requests.
//
// Ports: clk_i/rst_ni; host_req_i/host_gnt_o/host_we_i/host_addr_i/host_wdata_i/host_be_i request;
//        host_rvalid_o/host_rready_i/host_rdata_o/host_rerr_o response; ram_* drive the RAM port,
//        ram_rdata_i returns the word one cycle after a read; err_clr_i/err_count_o/err_valid_o/
//        err_addr_o form the parity-error log (saturating count, address of first error since clear).
module ram_1p_parity_adapter
  import ram_parity_pkg::*;
#(
  parameter  int unsigned Depth    = 128,
  parameter  int unsigned RspDepth = 2,
  localparam int unsigned Aw       = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 host_req_i,
  output logic                 host_gnt_o,
  input  logic                 host_we_i,
  input  logic [Aw-1:0]        host_addr_i,
  input  logic [DataWidth-1:0] host_wdata_i,
  input  logic [NB-1:0]        host_be_i,
  output logic                 host_rvalid_o,
  input  logic                 host_rready_i,
  output logic [DataWidth-1:0] host_rdata_o,
  output logic                 host_rerr_o,
  output logic                 ram_req_o,
  output logic                 ram_write_o,
  output logic [Aw-1:0]        ram_addr_o,
  output logic [RamWidth-1:0]  ram_wdata_o,
  output logic [RamWidth-1:0]  ram_wmask_o,
  input  logic [RamWidth-1:0]  ram_rdata_i,
  input  logic                 err_clr_i,
  output logic [15:0]          err_count_o,
  output logic                 err_valid_o,
  output logic [Aw-1:0]        err_addr_o
);

  localparam int unsigned  CntW        = $clog2(RspDepth + 1);
  localparam logic [CntW:0] CreditLimit = (CntW + 1)'(RspDepth);

  // Access issued last cycle; its RAM data (for reads) is on ram_rdata_i now.
  logic          r_inflight;
  logic          r_we;
  logic [Aw-1:0] r_addr;

  logic          r_err_valid;
  logic [15:0]   r_err_count;
  logic [Aw-1:0] r_err_addr;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  logic [CntW-1:0]      w_cnt;
  logic [CntW:0]        w_occ;
  logic [DataWidth-1:0] w_rd_data;
  logic [NB-1:0]        w_rd_par;
  logic                 w_rerr;
  logic                 w_err_push;
  rsp_t                 w_push_rsp;
  rsp_t                 w_head;

  // ---------------- credit / grant ----------------
  assign w_pop = host_rvalid_o & host_rready_i;
  // Occupancy the queue will see once the in-flight access lands, crediting a
  // pop happening this cycle so a draining queue still grants every cycle.
  assign w_occ = {1'b0, w_cnt} + {{CntW{1'b0}}, r_inflight} - {{CntW{1'b0}}, w_pop};
  assign host_gnt_o = host_req_i & (w_occ < CreditLimit);

  // ---------------- RAM drive ----------------
  assign ram_req_o   = host_req_i & host_gnt_o;
  assign ram_write_o = host_we_i;
  assign ram_addr_o  = host_addr_i;
  assign ram_wdata_o = {byte_parity(host_wdata_i), host_wdata_i};
  assign ram_wmask_o = be_to_mask(host_be_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inflight <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
    end else begin
      r_inflight <= host_gnt_o;
      if (host_gnt_o) begin
        r_we   <= host_we_i;
        r_addr <= host_addr_i;
      end
    end
  end

  // ---------------- read check / response build ----------------
  assign w_rd_data = ram_rdata_i[DataWidth-1:0];
  assign w_rd_par  = ram_rdata_i[RamWidth-1:DataWidth];
  // Data is returned as read; the error flag only reports the mismatch.
  assign w_rerr    = |(byte_parity(w_rd_data) ^ w_rd_par);

  always_comb begin
    w_push_rsp = '0;
    if (!r_we) begin
      w_push_rsp.rdata = w_rd_data;
      w_push_rsp.rerr  = w_rerr;
    end
  end

  // The credit rule keeps a full queue from ever meeting a push; the guard
  // only keeps FIFO state coherent should that invariant be broken.
  assign w_push = r_inflight & (~w_full | w_pop);

  ram_rsp_fifo #(
    .Width ($bits(rsp_t)),
    .Depth (RspDepth)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .wdata_i (w_push_rsp),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_cnt)
  );

  assign host_rvalid_o = ~w_empty;
  // Hold the response bus at zero whenever no response is presented.
  assign host_rdata_o  = host_rvalid_o ? w_head.rdata : '0;
  assign host_rerr_o   = host_rvalid_o & w_head.rerr;

  // ---------------- error log ----------------
  assign w_err_push = w_push & ~r_we & w_rerr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_count <= '0;
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_err_push) begin
      // A clear landing with an error restarts the log from this error.
      if (err_clr_i) begin
        r_err_count <= 16'd1;
      end else if (r_err_count != 16'hFFFF) begin
        r_err_count <= r_err_count + 16'd1;
      end
      if (err_clr_i || !r_err_valid) begin
        r_err_valid <= 1'b1;
        r_err_addr  <= r_addr;
      end
    end else if (err_clr_i) begin
      r_err_count <= '0;
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end
  end

  assign err_count_o = r_err_count;
  assign err_valid_o = r_err_valid;
  assign err_addr_o  = r_err_addr;

endmodule
